// File: rtl/seq_divider_pkg.sv
// Shared ALU definitions for the sequential divider: FSM encodings and result constants.
package seq_divider_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StRun  = 2'd1;
  localparam state_t StDone = 2'd2;

  // Widest operand supported; the divide-by-zero quotient is sliced from this.
  localparam int unsigned MaxWidth = 64;

  // Quotient reported on divide by zero (all ones at any width).
  localparam logic [MaxWidth-1:0] DbzQuotient = '1;

endpackage

// File: rtl/seq_divider_if.sv
// Start/done handshake and result bundle between the control unit and the divider.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 16
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_trial_sub.sv
// Trial subtractor a - b computed as a + ~b + 1 in generate/propagate carry form.
module div_trial_sub #(
  parameter int unsigned WIDTH = 17
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o
);

  logic [WIDTH-1:0] nb;
  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH:0]   carry;

  // Lookahead carries: carry-in of 1 supplies the +1 of the two's complement.
  always_comb begin
    nb       = ~b_i;
    gen      = a_i & nb;
    prop     = a_i ^ nb;
    carry    = '0;
    carry[0] = 1'b1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      carry[i+1] = gen[i] | (prop[i] & carry[i]);
    end
  end

  assign diff_o   = prop ^ carry[WIDTH-1:0];
  // No carry-out means a < b.
  assign borrow_o = ~carry[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, MSB first.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  seq_divider_if.slave div_io
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  // Upper bit of the partial remainder is always 0 after an iteration, so only
  // WIDTH bits are stored; the WIDTH+1-bit value exists only in the shift below.
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial_diff;
  logic             trial_borrow;
  logic             unused_diff_msb;

  assign r_shift = {r_q, q_q[WIDTH-1]};

  div_trial_sub #(
    .WIDTH(WIDTH + 1)
  ) u_trial_sub (
    .a_i     (r_shift),
    .b_i     ({1'b0, dvs_q}),
    .diff_o  (trial_diff),
    .borrow_o(trial_borrow)
  );

  assign unused_diff_msb = trial_diff[WIDTH];

  // Next-state: accept from IDLE or DONE, iterate in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dvs_d   = dvs_q;
    dbz_d   = dbz_q;
    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (div_io.start) begin
          cnt_d = '0;
          dvs_d = div_io.divisor;
          if (div_io.divisor == '0) begin
            state_d = StDone;
            q_d     = DbzQuotient[WIDTH-1:0];
            r_d     = div_io.dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = StRun;
            q_d     = div_io.dividend;
            r_d     = '0;
            dbz_d   = 1'b0;
          end
        end
      end
      StRun: begin
        cnt_d = cnt_q + CntW'(1);
        r_d   = trial_borrow ? r_shift[WIDTH-1:0] : trial_diff[WIDTH-1:0];
        q_d   = {q_q[WIDTH-2:0], ~trial_borrow};
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dvs_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dvs_q   <= dvs_d;
      dbz_q   <= dbz_d;
    end
  end

  assign div_io.busy        = (state_q == StRun);
  assign div_io.done        = (state_q == StDone);
  assign div_io.quotient    = q_q;
  assign div_io.remainder   = r_q;
  assign div_io.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed scoreboard bench for seq_divider at WIDTH=16.
module tb_seq_divider;

  localparam int unsigned W = 16;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(
    .WIDTH(W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .div_io(bus)
  );

  exp_t sb[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  int   lat_k;
  int   busy_c;
  int   d0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // Count done pulses and watch that busy and done never overlap.
  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
    if (rst_n === 1'b1) begin
      n_tests++;
      assert (!(bus.busy === 1'b1 && bus.done === 1'b1)) else begin
        n_fail++;
        $error("FAIL busy_done_overlap: observed busy=%0b done=%0b required not both 1",
               bus.busy, bus.done);
      end
    end
  end

  // Called at a negedge; drives one start cycle and returns at the negedge after accept.
  task automatic start_div(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.dbz = 1'b0;
    end
    sb.push_back(e);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = W'($urandom);
    bus.divisor  = W'($urandom);
  endtask

  // Waits (bounded) for done, then pops the scoreboard and compares the results.
  task automatic wait_done(input string tag, output int k, output int bc);
    exp_t e;
    k  = 0;
    bc = 0;
    while (bus.done !== 1'b1 && k < 64) begin
      if (bus.busy === 1'b1) bc++;
      @(negedge clk);
      k++;
    end
    check({tag, "_done_seen"}, {31'd0, bus.done}, 32'd1);
    check({tag, "_sb_nonempty"}, (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_quotient"}, {16'd0, bus.quotient}, {16'd0, e.q});
      check({tag, "_remainder"}, {16'd0, bus.remainder}, {16'd0, e.r});
      check({tag, "_dbz"}, {31'd0, bus.div_by_zero}, {31'd0, e.dbz});
    end
  endtask

  initial begin
    rst_n        = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_quotient", {16'd0, bus.quotient}, 32'd0);
    check("rst_remainder", {16'd0, bus.remainder}, 32'd0);
    check("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 100 / 7 with latency and busy-length checks.
    start_div(16'd100, 16'd7);
    wait_done("d100_7", lat_k, busy_c);
    check("d100_7_latency", lat_k + 1, 32'd17);
    check("d100_7_busy_cycles", busy_c, 32'd16);
    @(negedge clk);
    check("d100_7_done_one_cycle", {31'd0, bus.done}, 32'd0);
    check("d100_7_idle_busy", {31'd0, bus.busy}, 32'd0);

    start_div(16'hFFFF, 16'd1);
    wait_done("dffff_1", lat_k, busy_c);
    @(negedge clk);
    start_div(16'd5, 16'd9);
    wait_done("d5_9", lat_k, busy_c);
    @(negedge clk);
    start_div(16'd0, 16'd3);
    wait_done("d0_3", lat_k, busy_c);
    @(negedge clk);

    // Divide by zero, then a normal division clears the flag at accept.
    start_div(16'd1234, 16'd0);
    wait_done("d1234_0", lat_k, busy_c);
    check("d1234_0_latency", lat_k + 1, 32'd1);
    @(negedge clk);
    check("d1234_0_hold_dbz", {31'd0, bus.div_by_zero}, 32'd1);
    start_div(16'd50, 16'd5);
    check("d50_5_dbz_cleared_at_accept", {31'd0, bus.div_by_zero}, 32'd0);
    wait_done("d50_5", lat_k, busy_c);
    @(negedge clk);

    // start with new operands mid-RUN is ignored.
    start_div(16'd100, 16'd7);
    repeat (3) @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 16'd500;
    bus.divisor  = 16'd3;
    @(negedge clk);
    bus.start = 1'b0;
    d0 = done_cnt;
    wait_done("midrun", lat_k, busy_c);
    check("midrun_latency", lat_k + 4, 32'd16);
    repeat (20) @(negedge clk);
    check("midrun_single_done", done_cnt - d0, 32'd1);

    // Back-to-back: new start in the done cycle.
    start_div(16'd40000, 16'd300);
    wait_done("b2b_first", lat_k, busy_c);
    start_div(16'd77, 16'd7);
    wait_done("b2b_second", lat_k, busy_c);
    check("b2b_second_latency", lat_k + 1, 32'd17);
    @(negedge clk);

    // Asynchronous reset in the middle of RUN.
    start_div(16'd100, 16'd7);
    repeat (4) @(negedge clk);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_quotient", {16'd0, bus.quotient}, 32'd0);
    check("abort_remainder", {16'd0, bus.remainder}, 32'd0);
    check("abort_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 32'd0);
    start_div(16'd100, 16'd7);
    wait_done("after_abort", lat_k, busy_c);
    check("after_abort_latency", lat_k + 1, 32'd17);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative unsigned restoring divider for the RISC processor ALU, the inverse-direction companion of the combinational carry-lookahead adder path. It takes a dividend and divisor under a start/done handshake and produces quotient and remainder after a fixed number of cycles. Each cycle it resolves one quotient bit with a single trial subtraction. It sits beside the adder in the execute stage, and the control unit stalls on `busy`.

## Interface
- `WIDTH`, default 16: operand, quotient and remainder width in bits (≥2).
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a division; sampled only when not `busy`.
- `dividend`  in  WIDTH: unsigned dividend, sampled with `start`.
- `divisor`  in  WIDTH: unsigned divisor, sampled with `start`.
- `busy`  out  1: high while a division is in progress.
- `done`  out  1: one-cycle pulse; results are valid from this cycle.
- `quotient`  out  WIDTH: unsigned quotient.
- `remainder`  out  WIDTH: unsigned remainder.
- `div_by_zero`  out  1: set with `done` when the divisor was 0.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start` with divisor ≠ 0.
  - IDLE → DONE on `start` with divisor = 0.
  - RUN → DONE after WIDTH iterations.
  - DONE → IDLE unconditionally, unless `start` is high in the DONE cycle. In that case the new request is accepted exactly as from IDLE.
- Operands are captured into internal registers on accept, so later input changes have no effect.
- Iteration, MSB first:
  - Partial remainder R is WIDTH+1 bits, initialised to 0. Q is initialised to the dividend.
  - Shift {R,Q} left by 1 and compute T = R − {0,divisor} (WIDTH+1 bits, borrow = T[WIDTH]).
  - If there is no borrow: R←T and Q[0]←1. Otherwise R is unchanged and Q[0]←0.
  - An iteration counter of width $clog2(WIDTH+1) counts 0..WIDTH−1.
- In DONE, `quotient`=Q and `remainder`=R[WIDTH−1:0].
- Divide by zero: `quotient`=all ones, `remainder`=dividend, `div_by_zero`=1.
- `quotient`, `remainder` and `div_by_zero` hold their values until the next accept. At accept, `div_by_zero` clears. The result outputs read as don't-care while `busy`.
- `start` while `busy` is ignored; there is no queueing.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, counter=0.
- Accept at edge E.
  - Nonzero divisor: `busy`=1 from after E through E+WIDTH. `done`=1 and `busy`=0 in the cycle after edge E+WIDTH. Latency is WIDTH+1 cycles from the `start` cycle to the `done` cycle.
  - Zero divisor: `done` and `div_by_zero` are high in the cycle after E. Latency is 1 cycle.
- `done` is high for exactly one cycle per accepted request.
- `busy` and `done` are never high together.
- Back-to-back: `start` during the `done` cycle begins a new division with no idle gap.
- Asynchronous reset mid-RUN aborts immediately. No `done` is produced, and all outputs return to their reset values.

## Structure
- Shared ALU package:
  - state enum {IDLE, RUN, DONE}.
  - the divide-by-zero quotient constant (all ones).
- One sub-module, `div_trial_sub`:
  - Combinational (WIDTH+1)-bit subtractor producing difference and borrow.
  - Implemented as a + ~b + 1 on the team's carry-lookahead adder structure.
  - Borrow = NOT carry-out.

## Test plan
- WIDTH=16, 100 / 7 → `quotient`=14, `remainder`=2, `done` exactly 17 cycles after the `start` cycle, `busy` high 16 cycles.
- 0xFFFF / 1 → `quotient`=0xFFFF, `remainder`=0. Also 5 / 9 → `quotient`=0, `remainder`=5. Also 0 / 3 → both 0.
- 1234 / 0 → `done` 1 cycle after accept, `div_by_zero`=1, `quotient`=0xFFFF, `remainder`=1234. The next normal division clears `div_by_zero`.
- `start` with new operands pulsed mid-RUN → ignored; the first result is unchanged and only one `done` occurs.
- `start` asserted in the `done` cycle (40000 / 300, then 77 / 7) → second `done` 17 cycles later with 11 / 0; the first result is 133 / 100.
- `rst_n` pulsed low at cycle 5 of RUN → all outputs 0 immediately, no `done`. A fresh 100 / 7 afterwards completes correctly.
